dsa_bus_arbiter: RTL
====================

Name: dsa_bus_arbiter

Overview:
Round-robin arbiter that shares the single 8-bit memory-mapped DSA bus among NUM_REQ requesters. The bus carries the register bank plus input/output image RAM. Typical requesters are the host bridge, the fetch unit, the writeback unit and the debug/step unit. Supports locked bursts, a burst-length cap, and read responses returned in order after a fixed latency. Sits between the requesters and the register-bank/RAM address decoder.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 16, bus address width
DATA_W, 8, bus data width
MAX_BURST, 16, max transfers per grant before forced release (1..255)
RD_LAT, 1, cycles from read accept to bus_rdata valid (1..3)
TIMEOUT, 64, idle-owner cycles before forced release (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester access request
req_we  in  NUM_REQ  1=write, 0=read
req_last  in  NUM_REQ  final transfer of the burst; releases the lock
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_ready  out  NUM_REQ  one-hot; transfer accepted when req_valid & req_ready
rsp_valid  out  NUM_REQ  one-hot read-data strobe
rsp_rdata  out  DATA_W  read data
bus_addr  out  ADDR_W  to decoder/register bank
bus_wdata  out  DATA_W  write data
bus_wr_en  out  1  write strobe
bus_rd_en  out  1  read strobe
bus_rdata  in  DATA_W  read data from the bus
grant_id  out  $clog2(NUM_REQ)  current/last owner
busy  out  1  grant held
err_timeout  out  1  sticky watchdog flag

Behaviour:
- One clock, clk. Asynchronous active-high reset.
- Reset values: all outputs 0; state=IDLE; last_winner=NUM_REQ-1, so requester 0 has top priority; burst counter 0; response pipeline flushed.
- Reset mid-burst aborts immediately. Pending read responses are discarded.
- States: IDLE, OWN.
- IDLE:
  - If any req_valid, pick the first valid requester scanning from (last_winner+1) mod NUM_REQ upward with wrap.
  - Register it as owner and grant_id, set last_winner=owner, go to OWN.
  - No bus activity in IDLE (one arbitration cycle per grant). busy=0.
- OWN:
  - busy=1.
  - req_ready[owner]=1 combinationally; all other ready bits are 0.
  - Bus outputs are combinational from the owner's request: bus_addr/bus_wdata = owner's fields.
  - bus_wr_en = req_valid[owner] & req_we[owner].
  - bus_rd_en = req_valid[owner] & ~req_we[owner].
  - When the owner drops valid, strobes are 0 and the grant is kept (burst lock).
  - Each transfer increments the burst counter (8-bit, saturating at MAX_BURST).
  - Release (go to IDLE next cycle, counter cleared) on a transfer with req_last=1, or on the MAX_BURST-th transfer regardless of req_last.
  - After release, the previous owner has lowest priority at the next arbitration.
- Read response:
  - A shift pipe RD_LAT deep carries {valid, owner}.
  - RD_LAT cycles after a read accept: rsp_valid[owner]=1 and rsp_rdata=bus_rdata in the same cycle.
  - Responses complete even if the grant has since changed. Order is strictly in issue order.
- rsp_rdata holds its last value when rsp_valid=0.
- Writes have no response.
- A single requester with continuous single-transfer (last=1) requests gets 50% bus utilisation because of the IDLE cycle. This is acceptable.

Optional Feature:
DSA_ARB_TIMEOUT_EN
- Defined: in OWN, a counter increments each cycle req_valid[owner]=0 and clears on any owner valid.
  - On reaching TIMEOUT, forced release to IDLE and err_timeout set.
  - err_timeout is sticky until reset.
- Undefined: no counter, err_timeout tied 0, and an owner may hold the lock indefinitely.

Decomposition:
- Package dsa_arb_pkg: state enum arb_state_t {IDLE, OWN}; localparams for default NUM_REQ, MAX_BURST, RD_LAT; function rr_pick(valid, last_winner) returning the winner index.
- One natural sub-module, dsa_rsp_pipe: the RD_LAT-deep valid/id shift pipe with flush on reset.

Test Plan:
- Req0 writes 0x00→0x0000, 0x01→0x0001, 0x01→0x0002 (last on 3rd) → IDLE 1 cycle, then bus_wr_en high 3 consecutive cycles with matching addr/data, busy falls the cycle after the 3rd.
- After reset, req0/1/2 each raise a single last=1 write simultaneously → grants in order 0,1,2, each preceded by one IDLE cycle, with grant_id=0,1,2.
- Req1 reads 0x0010 with bus_rdata=0x5A, RD_LAT=1 → rsp_valid=4'b0010 and rsp_rdata=0x5A one cycle after accept.
- MAX_BURST=16: req0 streams 20 writes without last while req3 is valid → after the 16th transfer grant goes to req3; req0 regains the grant after req3 releases, and the remaining 4 complete.
- Reset asserted during req2's 5th burst read, with responses pending → all outputs 0 asynchronously, no rsp_valid after reset release, next grant goes to req0.
- With DSA_ARB_TIMEOUT_EN, TIMEOUT=8: owner req1 drops valid mid-burst → release after 8 cycles, err_timeout=1 stays set across later grants until reset; without the macro the grant is held and err_timeout=0.

Source files
------------

// File: rtl/dsa_arb_pkg.sv
// Shared types and helpers for the DSA bus arbiter: state encoding,
// default sizing and the round-robin winner selection.
package dsa_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_MAX_BURST = 16;
    localparam int DEF_RD_LAT    = 1;

    // First valid requester strictly after last_winner, wrapping at num_req.
    // Scanning the far end first lets the nearest candidate overwrite the pick.
    function automatic logic [2:0] rr_pick(
        input logic [7:0] valid,
        input logic [2:0] last_winner,
        input int         num_req
    );
        logic [2:0] pick;
        int         idx;
        pick = last_winner;
        for (int k = num_req; k >= 1; k--) begin
            idx = (int'(last_winner) + k) % num_req;
            if (valid[idx[2:0]]) begin
                pick = idx[2:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dsa_rsp_pipe.sv
// Fixed-latency shift pipe carrying {valid, requester id} for read responses;
// everything in flight is dropped on reset.
module dsa_rsp_pipe
#(
    parameter int DEPTH = 1,
    parameter int ID_W  = 2
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id
);

    logic [DEPTH-1:0]           valid_q, valid_d;
    logic [DEPTH-1:0][ID_W-1:0] id_q, id_d;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign valid_d[gi] = in_valid;
                assign id_d[gi]    = in_id;
            end else begin : g_tail
                assign valid_d[gi] = valid_q[gi-1];
                assign id_d[gi]    = id_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            id_q    <= '0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_id    = id_q[DEPTH-1];

endmodule

// File: rtl/dsa_bus_arbiter.sv
// Round-robin, burst-locking owner arbiter for the 8-bit DSA bus with in-order
// fixed-latency read responses. Define DSA_ARB_TIMEOUT_EN for the idle-owner watchdog.
module dsa_bus_arbiter
    import dsa_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int RD_LAT    = DEF_RD_LAT,
    parameter int TIMEOUT   = 64,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic [DATA_W-1:0]         bus_wdata,
    output logic                      bus_wr_en,
    output logic                      bus_rd_en,
    input  logic [DATA_W-1:0]         bus_rdata,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      err_timeout
);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   last_winner_q, last_winner_d;
    logic [7:0]        burst_q, burst_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              own, owner_valid, xfer, rd_accept, timeout_hit;
    logic              pipe_valid;
    logic [ID_W-1:0]   pipe_id;
    logic [2:0]        pick;

    assign own         = (state_q == OWN);
    assign owner_valid = req_valid[owner_q];
    assign xfer        = own & owner_valid;
    assign rd_accept   = xfer & ~req_we[owner_q];
    assign pick        = rr_pick(8'(req_valid), 3'(last_winner_q), NUM_REQ);
    assign busy        = own;
    assign grant_id    = owner_q;

`ifdef DSA_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
    logic            err_q, err_d;

    // Counts consecutive cycles the owner holds the lock without presenting a transfer.
    always_comb begin
        idle_cnt_d  = idle_cnt_q;
        err_d       = err_q;
        timeout_hit = 1'b0;
        if (!own || owner_valid) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q == TO_W'(TIMEOUT - 1)) begin
            idle_cnt_d  = '0;
            err_d       = 1'b1;
            timeout_hit = 1'b1;
        end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_winner_d = last_winner_q;
        burst_d       = burst_q;
        req_ready     = '0;
        bus_addr      = '0;
        bus_wdata     = '0;
        bus_wr_en     = 1'b0;
        bus_rd_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    owner_d       = pick[ID_W-1:0];
                    last_winner_d = pick[ID_W-1:0];
                    burst_d       = '0;
                    state_d       = OWN;
                end
            end
            OWN: begin
                req_ready[owner_q] = 1'b1;
                bus_addr           = req_addr[owner_q*ADDR_W +: ADDR_W];
                bus_wdata          = req_wdata[owner_q*DATA_W +: DATA_W];
                bus_wr_en          = owner_valid & req_we[owner_q];
                bus_rd_en          = rd_accept;
                if (xfer) begin
                    if (burst_q < 8'(MAX_BURST)) begin
                        burst_d = burst_q + 8'd1;
                    end
                    // The MAX_BURST-th beat ends the grant even without req_last.
                    if (req_last[owner_q] || (burst_q + 8'd1 >= 8'(MAX_BURST))) begin
                        state_d = IDLE;
                        burst_d = '0;
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    burst_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            last_winner_q <= ID_W'(NUM_REQ - 1);
            burst_q       <= '0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_winner_q <= last_winner_d;
            burst_q       <= burst_d;
            rdata_q       <= rdata_d;
        end
    end

    dsa_rsp_pipe #(
        .DEPTH (RD_LAT),
        .ID_W  (ID_W)
    ) u_rsp_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_accept),
        .in_id     (owner_q),
        .out_valid (pipe_valid),
        .out_id    (pipe_id)
    );

    // Read data passes straight through on the response cycle and is held afterwards.
    always_comb begin
        rsp_valid = '0;
        if (pipe_valid) begin
            rsp_valid[pipe_id] = 1'b1;
        end
        rsp_rdata = pipe_valid ? bus_rdata : rdata_q;
        rdata_d   = rsp_rdata;
    end

endmodule
